// File: rtl/dtw_query_ctrl.sv
// DTW query controller: sequences reference load, query sample streaming,
// datapath run, and emission of a 3-word result record to the sink FIFO.
// Ports:
//   clk, rst        clock, sync active-high reset
//   rs, op_mode     run strobe, 0=query 1=reference load
//   load_done       reference memory loaded
//   abort           cancel current operation
//   qry_len         runtime query length
//   threshold       hit threshold
//   busy, dtw_done  status
//   addr_ref        reference read pointer
//   src_fifo_*      source FIFO (first-word-fall-through) handshake
//   sink_fifo_*     sink FIFO handshake, record output
//   dp_*            datapath control/result
//   dbg_*           state, record and hit counters
module dtw_query_ctrl #(
  parameter int WIDTH            = 16,
  parameter int MAX_SQG_SIZE     = 1024,
  parameter int QLEN_WIDTH       = 11,
  parameter int REFMEM_PTR_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rs,
  input  logic                        op_mode,
  input  logic                        load_done,
  input  logic                        abort,
  input  logic [QLEN_WIDTH-1:0]       qry_len,
  input  logic [WIDTH-1:0]            threshold,
  output logic                        busy,
  output logic                        dtw_done,
  output logic [REFMEM_PTR_WIDTH-1:0] addr_ref,
  output logic                        src_fifo_clear,
  output logic                        src_fifo_rden,
  input  logic                        src_fifo_empty,
  input  logic [31:0]                 src_fifo_data,
  output logic                        sink_fifo_wren,
  input  logic                        sink_fifo_full,
  output logic [31:0]                 sink_fifo_data,
  output logic                        sink_fifo_last,
  output logic                        dp_rst,
  output logic                        dp_running,
  input  logic                        dp_done,
  input  logic [WIDTH-1:0]            dp_minval,
  input  logic [31:0]                 dp_position,
  output logic [2:0]                  dbg_state,
  output logic [31:0]                 dbg_nquery,
  output logic [31:0]                 dbg_nhit
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REF_LOAD = 3'd1,
    Q_INIT   = 3'd2,
    Q_RUN    = 3'd3,
    Q_DONE   = 3'd4
  } state_t;

  localparam logic [QLEN_WIDTH-1:0] MAX_LEN =
    QLEN_WIDTH'(MAX_SQG_SIZE);

  state_t state_q, state_d;

  logic                        busy_q, busy_d;
  logic                        clr_q, clr_d;
  logic                        dp_rst_q, dp_rst_d;
  logic [REFMEM_PTR_WIDTH-1:0] addr_q, addr_d;
  logic [QLEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic [QLEN_WIDTH-1:0]       len_q, len_d;
  logic [31:0]                 qid_q, qid_d;
  logic [31:0]                 pos_q, pos_d;
  logic [WIDTH-1:0]            minval_q, minval_d;
  logic                        hit_q, hit_d;
  logic [1:0]                  widx_q, widx_d;
  logic [31:0]                 nquery_q, nquery_d;
  logic [31:0]                 nhit_q, nhit_d;

  logic [QLEN_WIDTH-1:0]       eff_len;
  logic [31:0]                 word;

  // Zero or oversize lengths fall back to the largest supported query.
  assign eff_len = (qry_len == '0 || qry_len > MAX_LEN) ?
                   MAX_LEN : qry_len;

  always_comb begin
    unique case (widx_q)
      2'd0:    word = qid_q;
      2'd1:    word = pos_q;
      default: word = {hit_q, 15'b0, 16'(minval_q)};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    qid_d    = qid_q;
    pos_d    = pos_q;
    minval_d = minval_q;
    hit_d    = hit_q;
    widx_d   = widx_q;
    nquery_d = nquery_q;
    nhit_d   = nhit_q;

    busy_d   = (state_q != IDLE);
    clr_d    = (state_q == IDLE);
    dp_rst_d = (state_q == IDLE) || (state_q == REF_LOAD);

    src_fifo_rden  = 1'b0;
    dp_running     = 1'b0;
    sink_fifo_wren = 1'b0;
    sink_fifo_last = 1'b0;
    sink_fifo_data = 32'h0;
    dtw_done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rs && !op_mode && load_done)
          state_d = Q_INIT;
        else if (rs && op_mode && !load_done)
          state_d = REF_LOAD;
      end
      REF_LOAD: begin
        if (abort || load_done)
          state_d = IDLE;
      end
      Q_INIT: begin
        cnt_d  = '0;
        addr_d = '0;
        len_d  = eff_len;
        if (abort) begin
          state_d = IDLE;
        end else if (!src_fifo_empty) begin
          // First word of a query stream is its id.
          src_fifo_rden = 1'b1;
          qid_d         = src_fifo_data;
          state_d       = Q_RUN;
        end
      end
      Q_RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dp_done) begin
          minval_d = dp_minval;
          pos_d    = dp_position;
          hit_d    = (dp_minval <= threshold);
          widx_d   = 2'd0;
          state_d  = Q_DONE;
        end else if (cnt_q < len_q) begin
          // Datapath stalls while the source runs dry.
          if (!src_fifo_empty) begin
            src_fifo_rden = 1'b1;
            dp_running    = 1'b1;
            cnt_d         = cnt_q + QLEN_WIDTH'(1);
            addr_d        = addr_q + REFMEM_PTR_WIDTH'(1);
          end
        end else begin
          dp_running = 1'b1;
          addr_d     = addr_q + REFMEM_PTR_WIDTH'(1);
        end
      end
      Q_DONE: begin
        dtw_done       = 1'b1;
        sink_fifo_data = word;
        if (abort) begin
          state_d = IDLE;
        end else if (!sink_fifo_full) begin
          sink_fifo_wren = 1'b1;
          if (widx_q == 2'd2) begin
            sink_fifo_last = 1'b1;
            nquery_d       = nquery_q + 32'd1;
            nhit_d         = nhit_q + {31'd0, hit_q};
            widx_d         = 2'd0;
            state_d        = IDLE;
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Nothing leaves the block while reset is asserted.
    if (rst) begin
      src_fifo_rden  = 1'b0;
      dp_running     = 1'b0;
      sink_fifo_wren = 1'b0;
      sink_fifo_last = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      clr_q    <= 1'b1;
      dp_rst_q <= 1'b1;
      addr_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      qid_q    <= '0;
      pos_q    <= '0;
      minval_q <= '0;
      hit_q    <= 1'b0;
      widx_q   <= '0;
      nquery_q <= '0;
      nhit_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      clr_q    <= clr_d;
      dp_rst_q <= dp_rst_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      qid_q    <= qid_d;
      pos_q    <= pos_d;
      minval_q <= minval_d;
      hit_q    <= hit_d;
      widx_q   <= widx_d;
      nquery_q <= nquery_d;
      nhit_q   <= nhit_d;
    end
  end

  assign busy           = busy_q;
  assign src_fifo_clear = clr_q;
  assign dp_rst         = dp_rst_q;
  assign addr_ref       = addr_q;
  assign dbg_state      = state_q;
  assign dbg_nquery     = nquery_q;
  assign dbg_nhit       = nhit_q;

endmodule

// File: doc/dtw_query_ctrl.md
DTW_QUERY_CTRL -- requirements
Module: dtw_query_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, datapath score width.
REQ-002 Parameter MAX_SQG_SIZE, default 1024, largest query length in samples.
REQ-003 Parameter QLEN_WIDTH, default 11, width of qry_len; SHALL hold MAX_SQG_SIZE.
REQ-004 Parameter REFMEM_PTR_WIDTH, default 20, reference address width.
REQ-005 Ports, in the order given (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rs  in  1  run strobe.
- op_mode  in  1  0 = query mode, 1 = reference-load mode.
- load_done  in  1  reference memory loaded.
- abort  in  1  cancel the current operation.
- qry_len  in  QLEN_WIDTH  runtime query length.
- threshold  in  WIDTH  hit threshold.
- busy  out  1  high in every non-IDLE state.
- dtw_done  out  1  high while emitting a record.
- addr_ref  out  REFMEM_PTR_WIDTH  reference read pointer.
- src_fifo_clear  out  1  source FIFO clear.
- src_fifo_rden  out  1  source FIFO read enable.
- src_fifo_empty  in  1  source FIFO empty.
- src_fifo_data  in  32  source FIFO data.
- sink_fifo_wren  out  1  sink FIFO write enable.
- sink_fifo_full  in  1  sink FIFO full.
- sink_fifo_data  out  32  sink FIFO data.
- sink_fifo_last  out  1  last word of a record.
- dp_rst  out  1  datapath reset.
- dp_running  out  1  datapath advance.
- dp_done  in  1  datapath finished.
- dp_minval  in  WIDTH  best score.
- dp_position  in  32  best match position.
- dbg_state  out  3  FSM state.
- dbg_nquery  out  32  records emitted.
- dbg_nhit  out  32  hit records emitted.

Function
REQ-006 FSM states and encodings: IDLE=0, REF_LOAD=1, Q_INIT=2, Q_RUN=3, Q_DONE=4; other codes SHALL go to IDLE.
REQ-007 IDLE transitions: to Q_INIT on rs && op_mode==0 && load_done; to REF_LOAD on rs && op_mode==1 && !load_done; otherwise stay in IDLE.
REQ-008 REF_LOAD transitions: to IDLE when load_done==1.
REQ-009 Registered outputs, reflecting the state of the previous cycle:
- IDLE: busy=0, src_fifo_clear=1, dp_rst=1.
- REF_LOAD: busy=1, src_fifo_clear=0, dp_rst=1.
- All other states: busy=1, src_fifo_clear=0, dp_rst=0.
REQ-010 Q_INIT:
- src_fifo_rden=1 while the FIFO is not empty.
- The first non-empty word is latched as qid.
- eff_len is latched: qry_len if 1..MAX_SQG_SIZE; MAX_SQG_SIZE if qry_len is 0 or exceeds MAX_SQG_SIZE.
- sample_cnt and addr_ref are cleared to 0.
- Next state is Q_RUN.
REQ-011 Q_RUN load phase (sample_cnt < eff_len):
- FIFO not empty: src_fifo_rden=1, dp_running=1, sample_cnt+1, addr_ref+1.
- FIFO empty: src_fifo_rden=0, dp_running=0, counters hold (datapath stalls).
REQ-012 Q_RUN after the load phase: src_fifo_rden=0, dp_running=1, addr_ref+1 each cycle; addr_ref wraps modulo 2^REFMEM_PTR_WIDTH.
REQ-013 On dp_done in Q_RUN:
- Latch dp_minval and dp_position.
- Latch hit = (dp_minval <= threshold), unsigned compare.
- Go to Q_DONE with dp_running=0.
REQ-014 Q_DONE emits a 3-word record, dtw_done=1 throughout:
- word 0: qid.
- word 1: position.
- word 2: {hit, 15'b0, minval zero-extended to 16 bits}.
REQ-015 Record write rules:
- A word is presented with sink_fifo_wren=1 only in a cycle where sink_fifo_full was 0.
- If full, wren=0 and the word index holds.
- No word is skipped or duplicated.
REQ-016 sink_fifo_last=1 exactly with word 2 (wren=1); it is 0 otherwise.
REQ-017 After word 2 is written:
- dbg_nquery+1.
- dbg_nhit+1 if hit.
- Next state is IDLE.
REQ-018 abort=1 in any non-IDLE state forces IDLE on the next cycle:
- No record word is written after abort is sampled.
- Counters do not increment.
- abort is ignored in IDLE.
REQ-019 abort takes precedence over every other event in the same cycle, including dp_done or the write of word 2.
REQ-020 dbg_state SHALL equal the current state encoding.

Reset
REQ-021 rst=1 gives, on the next edge:
- state IDLE.
- busy, src_fifo_rden, sink_fifo_wren, sink_fifo_last, dtw_done, dp_running = 0.
- dp_rst=1, src_fifo_clear=1.
- addr_ref, sample_cnt, sink_fifo_data, dbg_nquery, dbg_nhit = 0.
REQ-022 rst mid-operation SHALL abandon the current query with no further sink writes; rst overrides abort and rs.

Verification
REQ-023 Reference load: op_mode=1, rs pulse, load_done rises after 10 cycles -> busy high about 10 cycles, then IDLE, dp_rst=1 throughout.
REQ-024 Normal query:
- Stimulus: qry_len=4, FIFO holds qid 0x2A plus 4 samples, dp_done after 20 cycles, dp_minval=0x0050, dp_position=0x1234, threshold=0x0100.
- Required response: sink gets 0x2A, 0x1234, 0x80000050; last only on the third word; dbg_nquery=1, dbg_nhit=1.
REQ-025 Source underflow: FIFO empties after 2 of 4 samples for 5 cycles -> dp_running=0 and addr_ref held for those 5 cycles; sample_cnt reaches 4 after refill.
REQ-026 Sink backpressure: sink_fifo_full held high for 3 cycles after word 0 -> words 1 and 2 follow once full drops, no duplicates; minval 0x0200 > threshold 0x0100 -> word 2 = 0x00000200, dbg_nhit unchanged.
REQ-027 Length clamp: qry_len=0 or qry_len=2000 with MAX_SQG_SIZE=1024 -> exactly 1024 samples read.
REQ-028 Abort and reset: abort in the same cycle as dp_done -> IDLE, no sink write, counters unchanged; rst during Q_DONE after word 0 -> no further writes, all outputs at reset values.
